bin_to_bcd_serial: RTL and testbench
====================================

Name: bin_to_bcd_serial

Overview:
Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) that sits directly upstream of the seven-segment decoder/scanner path. It converts a switch-supplied binary value into packed BCD digits, one bit per clock. It also produces a per-digit leading-zero blank mask so the display shows decimal values without leading zeros. Results are held stable between conversions so the scanned display never flickers mid-conversion.

Parameters:
IN_WIDTH, 8, width of binary input; conversion takes IN_WIDTH shift cycles
DIGITS, 4, number of BCD output digits; integration must ensure 10^DIGITS > 2^IN_WIDTH-1 (no hardware check)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request conversion of bin; sampled only in IDLE
bin  input  IN_WIDTH  binary value, captured on the accepting edge only
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: bcd/blank just updated
bcd  output  4*DIGITS  packed BCD; digit i = bcd[4i+3:4i], digit 0 = ones
blank  output  DIGITS  blank[i]=1: digit i is a leading zero (digit 0 never blanked)

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, done=0, bcd=0, blank={DIGITS-1 ones, 0}, internal shift/scratch/counter cleared. Reset mid-conversion aborts; no done pulse; bcd/blank return to reset values.
- States: IDLE, SHIFT.
- IDLE: start=1 at edge E0 -> capture bin into shift register, clear scratch (4*DIGITS bits), counter=IN_WIDTH, busy<=1, state<=SHIFT. start=0 -> stay; outputs hold.
- SHIFT, each edge: (1) every scratch nibble >= 5 gets +3 (4-bit, no carry between nibbles); (2) {scratch, shift} shifted left 1, shift MSB enters scratch LSB; counter decrements.
- Last shift edge (counter==1, edge E_IN_WIDTH): shifted scratch written to bcd; blank recomputed from that value (blank[i]=1 iff digit i and all higher digits are 0, i>0); done<=1; busy<=0; state<=IDLE.
- done high exactly one cycle; cleared on next edge unless a new conversion completes then (impossible for IN_WIDTH>=1).
- Latency: start accepted at E0 -> done high in the cycle following E_IN_WIDTH (8 cycles for default).
- bcd/blank change only on completion edge or reset; stable during SHIFT.
- start while busy=1 ignored (not queued). start high during the done cycle is accepted (state is IDLE); busy re-asserts at that edge, done drops.
- bin changes after acceptance have no effect on the in-flight conversion.
- Held start=1: back-to-back conversions, one every IN_WIDTH+1 cycles.

Test Plan:
- Reset values: hold reset=0 -> busy=0, done=0, bcd=16'h0000, blank=4'b1110; release, idle 5 cycles -> unchanged.
- bin=8'd255, start pulse -> busy high 8 cycles, done pulse 1 cycle after 8th shift edge, bcd=16'h0255, blank=4'b1000.
- bin=8'd0 -> bcd=16'h0000, blank=4'b1110; bin=8'd7 -> 16'h0007, 4'b1110; bin=8'd100 -> 16'h0100, blank=4'b1000.
- Convert 8'd42, then pulse start with bin=8'd99 at shift cycle 3 -> ignored; done once, bcd=16'h0042; bcd held 16'h0042 throughout subsequent idle.
- Hold start=1 with bin=8'd128 then 8'd19 on accept edges -> two done pulses 9 cycles apart, bcd 16'h0128 then 16'h0019, blank 4'b1000 then 4'b1100.
- Prior bcd=16'h0255; start bin=8'd33, assert reset=0 at shift cycle 4 (asynchronously, mid-cycle) -> outputs immediately reset values, no done; after release, convert 8'd33 -> bcd=16'h0033, blank=4'b1100.

Source files
------------

// File: rtl/bin_to_bcd_serial_if.sv
// Handshake and result bundle between the switch front end and the serial BCD converter.
interface bin_to_bcd_serial_if #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned DIGITS   = 4
);
    logic                  start;
    logic [IN_WIDTH-1:0]   bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, blank
    );
endinterface

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one input bit per clock, with a
// leading-zero blank mask. Results are held between conversions.
module bin_to_bcd_serial #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned DIGITS   = 4
) (
    input logic                clock,
    input logic                reset,
    bin_to_bcd_serial_if.slave bus
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(IN_WIDTH + 1);
    localparam logic [DIGITS-1:0] BlankRst = ~DIGITS'(1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e              state_q;
    logic [IN_WIDTH-1:0] shift_q;
    logic [BcdW-1:0]     scratch_q;
    logic [BcdW-1:0]     scratch_d;
    logic [BcdW-1:0]     adj;
    logic [BcdW-1:0]     bcd_q;
    logic [DIGITS-1:0]   blank_q;
    logic [DIGITS-1:0]   blank_d;
    logic [CntW-1:0]     cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                lead_nz;

    // Add-3 per nibble (no inter-nibble carry), then shift in the next input bit.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_d = {adj[BcdW-2:0], shift_q[IN_WIDTH-1]};
    end

    // A digit blanks only while it and every digit above it are zero; ones never blanks.
    always_comb begin
        lead_nz = 1'b0;
        blank_d = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            lead_nz    = lead_nz | (scratch_d[4*i +: 4] != 4'd0);
            blank_d[i] = ~lead_nz;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            blank_q   <= BlankRst;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        shift_q   <= bus.bin;
                        scratch_q <= '0;
                        cnt_q     <= CntW'(IN_WIDTH);
                        busy_q    <= 1'b1;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    shift_q   <= shift_q << 1;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        bcd_q   <= scratch_d;
                        blank_q <= blank_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.bcd   = bcd_q;
    assign bus.blank = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Scoreboard bench for bin_to_bcd_serial: expected digits come from a divide/modulo model.
module tb_bin_to_bcd_serial;

    localparam int unsigned IN_WIDTH = 8;
    localparam int unsigned DIGITS   = 4;

    logic clock;
    logic reset;

    bin_to_bcd_serial_if #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_serial #(
        .IN_WIDTH(IN_WIDTH),
        .DIGITS  (DIGITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    logic [19:0] sb[$];

    // Returns {bcd[15:0], blank[3:0]} computed arithmetically.
    function automatic logic [19:0] model(input logic [7:0] v);
        logic [15:0] b;
        logic [3:0]  bl;
        int          x;
        logic        nz;
        x  = int'(v);
        b  = '0;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        nz = 1'b0;
        bl = 4'b0000;
        for (int i = 3; i >= 1; i--) begin
            nz    = nz | (b[4*i +: 4] != 4'd0);
            bl[i] = ~nz;
        end
        return {b, bl};
    endfunction

    // Scoreboard monitor: every done pulse pops one expected result.
    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            logic [19:0] exp_v;
            done_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got bcd=%h blank=%b, required no done", bus.bcd,
                         bus.blank);
            end else begin
                exp_v = sb.pop_front();
                if ({bus.bcd, bus.blank} !== exp_v) begin
                    errors++;
                    $display("FAIL sb_result: got bcd=%h blank=%b, required bcd=%h blank=%b",
                             bus.bcd, bus.blank, exp_v[19:4], exp_v[3:0]);
                end
            end
        end
    end

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b, required 0", bus.done);
        end
        checks++;
        if (bus.bcd !== 16'h0000) begin
            errors++; $display("FAIL reset_bcd: got %h, required 0000", bus.bcd);
        end
        checks++;
        if (bus.blank !== 4'b1110) begin
            errors++; $display("FAIL reset_blank: got %b, required 1110", bus.blank);
        end
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if ({bus.busy, bus.done, bus.bcd, bus.blank} !== {2'b00, 16'h0000, 4'b1110}) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got busy=%b done=%b bcd=%h blank=%b, required 0 0 0000 1110",
                         c, bus.busy, bus.done, bus.bcd, bus.blank);
            end
        end
    endtask

    task automatic test_conversion(input logic [7:0] v);
        int          n;
        logic        stable;
        logic [19:0] prev;
        @(negedge clock);
        bus.bin   = v;
        bus.start = 1'b1;
        sb.push_back(model(v));
        prev = {bus.bcd, bus.blank};
        @(negedge clock);
        bus.start = 1'b0;
        bus.bin   = ~v;
        n      = 0;
        stable = 1'b1;
        while (bus.busy === 1'b1 && n < 20) begin
            if ({bus.bcd, bus.blank} !== prev || bus.done !== 1'b0) stable = 1'b0;
            n++;
            @(negedge clock);
        end
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL conv_busy_len bin=%0d: got %0d cycles, required 8", v, n);
        end
        checks++;
        if (!stable) begin
            errors++; $display("FAIL conv_hold bin=%0d: got output change during shift, required stable", v);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++; $display("FAIL conv_done bin=%0d: got %b, required 1", v, bus.done);
        end
        @(negedge clock);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL conv_done_width bin=%0d: got %b, required 0", v, bus.done);
        end
    endtask

    task automatic test_ignore_busy();
        int d0;
        @(negedge clock);
        bus.bin   = 8'd42;
        bus.start = 1'b1;
        sb.push_back(model(8'd42));
        d0 = done_seen;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        bus.bin   = 8'd99;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (20) @(negedge clock);
        checks++;
        if (done_seen - d0 != 1) begin
            errors++; $display("FAIL ignore_done_count: got %0d, required 1", done_seen - d0);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if ({bus.bcd, bus.blank} !== {16'h0042, 4'b1100}) begin
                errors++;
                $display("FAIL ignore_hold: got bcd=%h blank=%b, required 0042 1100", bus.bcd, bus.blank);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, cyc;
        t1 = -1;
        t2 = -1;
        @(negedge clock);
        bus.bin   = 8'd128;
        bus.start = 1'b1;
        sb.push_back(model(8'd128));
        for (cyc = 0; cyc < 40 && t2 < 0; cyc++) begin
            @(negedge clock);
            if (t1 >= 0 && cyc == t1 + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    bus.bin = 8'd19;
                    sb.push_back(model(8'd19));
                end else begin
                    t2 = cyc;
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (t1 < 0 || t2 < 0 || t2 - t1 != 9) begin
            errors++; $display("FAIL b2b_spacing: got t1=%0d t2=%0d, required 9 cycles apart", t1, t2);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int d0;
        test_conversion(8'd255);
        @(negedge clock);
        bus.bin   = 8'd33;
        bus.start = 1'b1;
        d0 = done_seen;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.bcd, bus.blank} !== {2'b00, 16'h0000, 4'b1110}) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b bcd=%h blank=%b, required 0 0 0000 1110",
                     bus.busy, bus.done, bus.bcd, bus.blank);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        checks++;
        if (done_seen != d0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abort: got %0d done pulses busy=%b, required 0 and busy 0",
                     done_seen - d0, bus.busy);
        end
        test_conversion(8'd33);
        checks++;
        if ({bus.bcd, bus.blank} !== {16'h0033, 4'b1100}) begin
            errors++;
            $display("FAIL midreset_reconvert: got bcd=%h blank=%b, required 0033 1100", bus.bcd,
                     bus.blank);
        end
    endtask

    initial begin
        test_reset();
        test_conversion(8'd255);
        test_conversion(8'd0);
        test_conversion(8'd7);
        test_conversion(8'd100);
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d pending results, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
